// File: rtl/mb8_pkg.sv
// Shared widths, bus types and arbiter state encoding for the mb8 memory bus.
package mb8_pkg;

  localparam int ASZ = 17;
  localparam int DSZ = 8;

  typedef logic [ASZ-1:0] addr_t;
  typedef logic [DSZ-1:0] data_t;

  typedef enum logic {IDLE, OWN} arb_st_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request strictly after `last`,
// wrapping, with `last` itself as the lowest-priority candidate.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int LW = $clog2(NREQ);

  // Walk from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    logic [LW-1:0] j;
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = LW'((int'(last) + k) % NREQ);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/mb8_arbiter.sv
// Round-robin arbiter sharing one 8-bit SPRAM port among NREQ mb8 masters,
// with a per-burst cycle limit and a 1-deep read-valid return pipeline.
//
// state | meaning
// IDLE  | no owner, gnt is zero
// OWN   | master `last_q` owns the bus; gnt_q is its one-hot grant
module mb8_arbiter #(
  parameter int NREQ = 4,
  parameter int ASZ  = mb8_pkg::ASZ,
  parameter int DSZ  = mb8_pkg::DSZ,
  parameter int MAXB = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     we,
  input  logic [NREQ*ASZ-1:0] ai,
  input  logic [NREQ*DSZ-1:0] vi,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rvld,
  output logic [DSZ-1:0]      vo,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ASZ-1:0]      mem_a,
  output logic [DSZ-1:0]      mem_vi,
  input  logic [DSZ-1:0]      mem_vo
);

  import mb8_pkg::*;

  localparam int LW = $clog2(NREQ);
  localparam int BW = (MAXB > 0) ? $clog2(MAXB + 1) : 1;

  arb_st_t         state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvld_q, rvld_d;
  logic [LW-1:0]   last_q, last_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;

  logic            pick_any;
  logic [LW-1:0]   pick_idx;
  logic            own, owner_req, access, burst_end;

  // Masking the current owner lets one picker serve both the idle grant
  // (gnt_q is zero) and the hand-over, where only competitors count.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req & ~gnt_q),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // The owner index is always last_q while in OWN.
  assign own       = (state_q == OWN);
  assign owner_req = req[last_q];
  assign access    = own & owner_req;
  assign burst_end = (MAXB != 0) && (int'(bcnt_q) == MAXB - 1);

  assign mem_en = access;
  assign mem_we = access & we[last_q];
  assign mem_a  = own ? ai[int'(last_q)*ASZ +: ASZ] : '0;
  assign mem_vi = own ? vi[int'(last_q)*DSZ +: DSZ] : '0;
  assign vo     = mem_vo;
  assign gnt    = gnt_q;
  assign rvld   = rvld_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    rvld_d  = (access && !we[last_q]) ? gnt_q : '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d          = OWN;
          gnt_d            = '0;
          gnt_d[pick_idx]  = 1'b1;
          last_d           = pick_idx;
          bcnt_d           = '0;
        end
      end
      OWN: begin
        if (!owner_req || (burst_end && pick_any)) begin
          if (pick_any) begin
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            last_d          = pick_idx;
            bcnt_d          = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (int'(bcnt_q) < MAXB) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rvld_q  <= '0;
      last_q  <= LW'(NREQ - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rvld_q  <= rvld_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_mb8_arbiter.sv
// Scoreboard bench for mb8_arbiter: expected grant changes and read returns
// are queued by the stimulus and consumed by a negedge monitor.
module tb_mb8_arbiter;

  localparam int N = 4;
  localparam int A = 17;
  localparam int D = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     we  = '0;
  logic [N*A-1:0]   ai  = '0;
  logic [N*D-1:0]   vi  = '0;
  logic [N-1:0]     gnt, rvld;
  logic [D-1:0]     vo;
  logic             mem_en, mem_we;
  logic [A-1:0]     mem_a;
  logic [D-1:0]     mem_vi;
  logic [D-1:0]     mem_vo = '0;

  logic [7:0] mem [0:1023];

  typedef struct {int m; logic [7:0] d; int c;} rd_t;
  rd_t        exp_rd[$];
  logic [3:0] exp_gnt[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [3:0] prev_gnt = '0;

  mb8_arbiter #(.NREQ(N), .ASZ(A), .DSZ(D), .MAXB(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .ai(ai), .vi(vi),
    .gnt(gnt), .rvld(rvld), .vo(vo),
    .mem_en(mem_en), .mem_we(mem_we), .mem_a(mem_a), .mem_vi(mem_vi),
    .mem_vo(mem_vo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_a[9:0]] <= mem_vi;
      else        mem_vo <= mem[mem_a[9:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
  endtask

  // One master: n accesses starting at a0; data d0 is written, or expected
  // back on reads; address and data advance by inc after each access.
  task automatic master(input int m, input int n, input bit wr,
                        input logic [16:0] a0, input logic [7:0] d0, input int inc);
    int k = 0;
    int t = 0;
    bit g;
    logic [16:0] a;
    logic [7:0]  d;
    rd_t r;
    a = a0;
    d = d0;
    we[m] = wr;
    ai[m*A +: A] = a;
    vi[m*D +: D] = wr ? d : 8'h00;
    req[m] = 1'b1;
    while (k < n && t < 300) begin
      #1;
      g = gnt[m];
      if (g) begin
        chk("acc_en", {31'd0, mem_en}, 32'd1);
        chk("acc_we", {31'd0, mem_we}, {31'd0, wr});
        chk("acc_addr", {15'd0, mem_a}, {15'd0, a});
        if (wr) chk("acc_wdata", {24'd0, mem_vi}, {24'd0, d});
      end
      @(posedge clk);
      #1;
      t++;
      if (g) begin
        if (!wr) begin
          r.m = m; r.d = d; r.c = cyc;
          exp_rd.push_back(r);
        end
        k++;
        a = a + 17'(inc);
        d = d + 8'(inc);
        ai[m*A +: A] = a;
        vi[m*D +: D] = wr ? d : 8'h00;
      end
    end
    req[m] = 1'b0;
    if (k < n) begin
      total++;
      bad++;
      $display("FAIL master%0d_timeout: got %0d accesses want %0d", m, k, n);
    end
  endtask

  initial begin : monitor
    rd_t r;
    logic [3:0] eg;
    forever begin
      @(negedge clk);
      if (gnt !== prev_gnt) begin
        if (exp_gnt.size() == 0) begin
          total++;
          bad++;
          $display("FAIL gnt_unexpected: got %0h want %0h", gnt, prev_gnt);
        end else begin
          eg = exp_gnt.pop_front();
          chk("gnt_seq", {28'd0, gnt}, {28'd0, eg});
        end
        prev_gnt = gnt;
      end
      if (rvld !== '0) begin
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rvld_unexpected: got %0h want 0", rvld);
        end else begin
          r = exp_rd.pop_front();
          chk("rvld_who", {28'd0, rvld}, 32'd1 << r.m);
          chk("rvld_data", {24'd0, vo}, {24'd0, r.d});
          chk("rvld_cycle", cyc, r.c);
        end
      end
    end
  end

  initial begin : stim
    int cnt;
    #2;
    do_reset;
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_rvld", {28'd0, rvld}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", {15'd0, mem_a}, 32'd0);
    chk("rst_mem_vi", {24'd0, mem_vi}, 32'd0);
    tick;

    // single master write then read-back
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0000);
    fork
      master(0, 1, 1'b1, 17'h0010, 8'h41, 0);
      begin tick; #1; chk("gnt_latency", {28'd0, gnt}, 32'd1); end
    join
    repeat (3) tick;
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0000);
    master(0, 1, 1'b0, 17'h0010, 8'h41, 0);
    repeat (3) tick;

    // all four request together right after reset
    do_reset;
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010);
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000);
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0000);
    fork
      begin
        master(0, 2, 1'b1, 17'h0200, 8'h00, 1);
        tick;
        master(0, 2, 1'b1, 17'h0204, 8'h04, 1);
      end
      master(1, 2, 1'b1, 17'h0210, 8'h10, 1);
      master(2, 2, 1'b1, 17'h0220, 8'h20, 1);
      master(3, 2, 1'b1, 17'h0230, 8'h30, 1);
    join
    repeat (3) tick;

    // preload "abcd", then finder reads while master 3 writes elsewhere
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0000);
    master(0, 4, 1'b1, 17'h0000, 8'h61, 1);
    repeat (3) tick;
    exp_gnt.push_back(4'b1000); exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0000);
    fork
      master(0, 4, 1'b0, 17'h0000, 8'h61, 1);
      master(3, 4, 1'b1, 17'h0100, 8'hA0, 1);
    join
    repeat (3) tick;

    // burst limit: master 1 reads 'c' continuously, master 2 arrives later
    exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0100);
    exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0000);
    fork
      master(1, 20, 1'b0, 17'h0002, 8'h63, 0);
      begin repeat (5) tick; master(2, 3, 1'b1, 17'h0080, 8'h55, 1); end
      begin
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (gnt == 4'b0100) break;
          if (gnt == 4'b0010) cnt++;
        end
        chk("burst_len", cnt, 32'd16);
        chk("preempt_gnt", {28'd0, gnt}, 32'b0100);
        chk("lastcyc_rvld", {28'd0, rvld}, 32'b0010);
        chk("lastcyc_vo", {24'd0, vo}, 32'h63);
      end
    join
    repeat (3) tick;

    // a lone master is never preempted
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0000);
    master(0, 20, 1'b1, 17'h0040, 8'h00, 1);
    repeat (3) tick;

    // reset mid-burst with a read in flight
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b0000);
    we[2] = 1'b0; ai[2*A +: A] = 17'h0000; req = 4'b0100;
    tick; tick;
    chk("rvld_pre_rst", {28'd0, rvld}, 32'b0100);
    #2 rst = 1'b0;
    #1;
    chk("rst_rd_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_rd_rvld", {28'd0, rvld}, 32'd0);
    chk("rst_rd_mem_en", {31'd0, mem_en}, 32'd0);
    req = '0;
    tick;
    rst = 1'b1;
    tick;

    // reset mid-burst during writes
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b0000);
    we[2] = 1'b1; ai[2*A +: A] = 17'h0300; vi[2*D +: D] = 8'h77; req = 4'b0100;
    tick; tick;
    #2 rst = 1'b0;
    #1;
    chk("rst_wr_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_wr_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_wr_mem_we", {31'd0, mem_we}, 32'd0);
    req = '0;
    tick;
    rst = 1'b1;
    tick;

    // arbitration restarts from master 0
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0000);
    we = '0;
    req = 4'b1111;
    tick;
    #1;
    chk("restart_m0", {28'd0, gnt}, 32'b0001);
    req = '0;
    repeat (4) tick;

    chk("gnt_queue_empty", exp_gnt.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
